stream_out_scheduler: RTL

Single-output packet scheduler that sequences a leaf's outbound traffic onto its one upstream `stream_out` link. It shares that link between two requester classes: freespace-update credit packets raised by the input-port cluster, and data packets queued in the output-port FIFOs. It sits between the input/output port clusters and the leaf's relay interface inside the stream flow-control wrapper. It honours link-level `resend` backpressure from the relay.

---
 rtl/stream_out_scheduler.sv | 131 +++++++++++++
 1 files changed

// File: rtl/stream_out_scheduler.sv
// Shares one upstream stream_out link between freespace-update credit packets
// and output-FIFO data packets, with a bounded credit burst and resend hold.
module stream_out_scheduler #(
  parameter int PACKET_BITS   = 97,
  parameter int NUM_IN_PORTS  = 7,
  parameter int NUM_OUT_PORTS = 7,
  parameter int FS_BURST      = 4
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 resend,
  input  logic [NUM_IN_PORTS-1:0]              freespace_update,
  input  logic [PACKET_BITS*NUM_IN_PORTS-1:0]  packet_from_input_ports,
  input  logic [PACKET_BITS*NUM_OUT_PORTS-1:0] packet_from_output_ports,
  input  logic [NUM_OUT_PORTS-1:0]             empty,
  output logic [NUM_OUT_PORTS-1:0]             outport_sel,
  output logic [PACKET_BITS-1:0]               stream_out
);

  localparam int IN_W  = (NUM_IN_PORTS  > 1) ? $clog2(NUM_IN_PORTS)  : 1;
  localparam int OUT_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
  localparam logic [3:0] BURST   = 4'(FS_BURST);
  localparam logic [3:0] RUN_MAX = 4'd15;

  typedef enum logic [1:0] {IDLE, SEND_FS, SEND_DATA} state_e;

  state_e                   state_q, state_d;
  logic [NUM_IN_PORTS-1:0]  fs_pend_q, fs_pend_d;
  logic [PACKET_BITS-1:0]   fs_pkt_q [NUM_IN_PORTS];
  logic [IN_W-1:0]          fs_ptr_q, fs_ptr_d, fs_win;
  logic [OUT_W-1:0]         d_ptr_q, d_ptr_d, d_win;
  logic [3:0]               fs_run_q, fs_run_d;
  logic [PACKET_BITS-1:0]   stream_out_q, stream_out_d;
  logic                     fs_req, d_req, grant_fs;

  // First requester at or after ptr, wrapping; lowest offset wins.
  function automatic logic [IN_W-1:0] pick_in(input logic [NUM_IN_PORTS-1:0] req,
                                               input logic [IN_W-1:0] ptr);
    int idx;
    pick_in = ptr;
    for (int off = NUM_IN_PORTS - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_IN_PORTS) idx -= NUM_IN_PORTS;
      if (req[IN_W'(idx)]) pick_in = IN_W'(idx);
    end
  endfunction

  function automatic logic [OUT_W-1:0] pick_out(input logic [NUM_OUT_PORTS-1:0] req,
                                                input logic [OUT_W-1:0] ptr);
    int idx;
    pick_out = ptr;
    for (int off = NUM_OUT_PORTS - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_OUT_PORTS) idx -= NUM_OUT_PORTS;
      if (req[OUT_W'(idx)]) pick_out = OUT_W'(idx);
    end
  endfunction

  assign fs_req = |fs_pend_q;
  assign d_req  = |(~empty);
  assign fs_win = pick_in(fs_pend_q, fs_ptr_q);
  assign d_win  = pick_out(~empty, d_ptr_q);

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    fs_ptr_d     = fs_ptr_q;
    d_ptr_d      = d_ptr_q;
    fs_run_d     = fs_run_q;
    stream_out_d = stream_out_q;
    outport_sel  = '0;
    grant_fs     = 1'b0;
    if (!reset && !resend) begin
      if (fs_req && (!d_req || fs_run_q < BURST)) begin
        grant_fs     = 1'b1;
        state_d      = SEND_FS;
        stream_out_d = fs_pkt_q[fs_win];
        fs_ptr_d     = (fs_win == IN_W'(NUM_IN_PORTS - 1)) ? '0 : fs_win + 1'b1;
        if (!d_req)                fs_run_d = '0;
        else if (fs_run_q != RUN_MAX) fs_run_d = fs_run_q + 4'd1;
      end else if (d_req) begin
        state_d              = SEND_DATA;
        outport_sel[d_win]   = 1'b1;
        stream_out_d         = packet_from_output_ports[int'(d_win)*PACKET_BITS +: PACKET_BITS];
        d_ptr_d              = (d_win == OUT_W'(NUM_OUT_PORTS - 1)) ? '0 : d_win + 1'b1;
        fs_run_d             = '0;
      end else begin
        state_d      = IDLE;
        stream_out_d = '0;
        fs_run_d     = '0;
      end
    end
  end

  // A fresh pulse beats a same-cycle grant, so the newer credit stays pending.
  always_comb begin
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      fs_pend_d[i] = freespace_update[i] |
                     (fs_pend_q[i] & ~(grant_fs && (fs_win == IN_W'(i))));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      fs_pend_q    <= '0;
      fs_ptr_q     <= '0;
      d_ptr_q      <= '0;
      fs_run_q     <= '0;
      stream_out_q <= '0;
    end else begin
      state_q      <= state_d;
      fs_pend_q    <= fs_pend_d;
      fs_ptr_q     <= fs_ptr_d;
      d_ptr_q      <= d_ptr_d;
      fs_run_q     <= fs_run_d;
      stream_out_q <= stream_out_d;
    end
  end

  // NOTE: payload storage needs no reset; it is only read while its pending flag is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_IN_PORTS; i++) begin
      if (freespace_update[i]) fs_pkt_q[i] <= packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS];
    end
  end

  assign stream_out = stream_out_q;

endmodule
